// File: rtl/l2q_pkg.sv
// Shared types and helpers for the L1-to-L2 request queue.
package l2q_pkg;

  typedef enum logic [1:0] {
    DATA_READ          = 2'b00,
    DATA_WRITE_THROUGH = 2'b01,
    INSTR_READ         = 2'b10,
    DATA_WRITE_BACK    = 2'b11
  } l2q_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_RESP = 2'b10
  } l2q_state_t;

  // 64-byte L2 block
  localparam int unsigned L2Q_OFFSET_W = 6;

  function automatic logic is_read(input l2q_op_t op);
    return (op == DATA_READ) || (op == INSTR_READ);
  endfunction

endpackage

// File: rtl/l2q_fifo.sv
// Synchronous FIFO of {op, addr} request entries with occupancy flags.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module l2q_fifo
  import l2q_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  l2q_op_t                  wr_op,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     pop,
  output l2q_op_t                  rd_op,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  l2q_op_t           op_mem_q   [DEPTH];
  l2q_op_t           op_mem_d   [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_d [DEPTH];
  logic              push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_op   = op_mem_q[rd_ptr_q];
  assign rd_addr = addr_mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers, occupancy and storage contents
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_mem_d   = op_mem_q;
    addr_mem_d = addr_mem_q;
    if (push_ok) begin
      op_mem_d[wr_ptr_q]   = wr_op;
      addr_mem_d[wr_ptr_q] = wr_addr;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    op_mem_q   <= op_mem_d;
    addr_mem_q <= addr_mem_d;
  end

endmodule

// File: rtl/l1_l2_request_queue.sv
// In-order L1-to-L2 request queue with a single outstanding L2 read.
// Optional statistics counters are enabled by defining L2Q_STATS_EN.
module l1_l2_request_queue
  import l2q_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = L2Q_OFFSET_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    l2_valid,
  input  logic                    l2_ready,
  output logic [1:0]              l2_op,
  output logic [ADDR_W-1:0]       l2_addr,
  input  logic                    l2_rvalid,
  output logic                    fill_valid,
  output logic [1:0]              fill_op,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
`ifdef L2Q_STATS_EN
  ,
  output logic [31:0]             stat_reads,
  output logic [31:0]             stat_writes,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  l2q_state_t        state_q, state_d;
  logic              fill_valid_q, fill_valid_d;
  l2q_op_t           fill_op_q, fill_op_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;

  l2q_op_t           head_op;
  logic [ADDR_W-1:0] head_addr, head_aligned;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              l2_valid_int;

  assign push         = req_valid && !fifo_full;
  assign head_aligned = head_addr & ~OFFSET_MASK;

  // ISSUE is held off for the fill cycle so the next request follows the fill notification
  assign l2_valid_int = (state_q == ISSUE) && !fill_valid_q;

  l2q_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_op   (l2q_op_t'(req_op)),
    .wr_addr (req_addr),
    .pop     (pop),
    .rd_op   (head_op),
    .rd_addr (head_addr),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issue FSM: next state, head pop and fill notification
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    fill_valid_d = 1'b0;
    fill_op_d    = fill_op_q;
    fill_addr_d  = fill_addr_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        if (l2_valid_int && l2_ready) begin
          if (is_read(head_op)) begin
            state_d = WAIT_RESP;
          end else begin
            pop     = 1'b1;
            state_d = (fifo_count > CW'(1)) ? ISSUE : IDLE;
          end
        end
      end
      WAIT_RESP: begin
        if (l2_rvalid) begin
          pop          = 1'b1;
          fill_valid_d = 1'b1;
          fill_op_d    = head_op;
          fill_addr_d  = head_aligned;
          state_d      = (fifo_count > CW'(1)) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and fill notification registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_valid_q <= 1'b0;
      fill_op_q    <= DATA_READ;
      fill_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fill_valid_q <= fill_valid_d;
      fill_op_q    <= fill_op_d;
      fill_addr_q  <= fill_addr_d;
    end
  end

  assign req_ready  = !fifo_full;
  assign l2_valid   = l2_valid_int;
  assign l2_op      = l2_valid_int ? head_op : 2'b00;
  assign l2_addr    = l2_valid_int ? head_aligned : '0;
  assign fill_valid = fill_valid_q;
  assign fill_op    = fill_op_q;
  assign fill_addr  = fill_addr_q;
  assign count      = fifo_count;
  assign busy       = (fifo_count != '0) || (state_q != IDLE);

`ifdef L2Q_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Saturating handshake and stall counters
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_stalls_d = stat_stalls_q;
    if (l2_valid_int && l2_ready) begin
      if (is_read(head_op)) begin
        if (stat_reads_q != '1) stat_reads_d = stat_reads_q + 32'd1;
      end else begin
        if (stat_writes_q != '1) stat_writes_d = stat_writes_q + 32'd1;
      end
    end
    if (l2_valid_int && !l2_ready) begin
      if (stat_stalls_q != '1) stat_stalls_d = stat_stalls_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_l1_l2_request_queue.sv
// Directed scoreboard bench for l1_l2_request_queue.
// Define L2Q_STATS_EN to include the statistics ports and their test.
module tb_l1_l2_request_queue;
  import l2q_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, l2_valid, l2_ready, l2_rvalid;
  logic        fill_valid, busy;
  logic [1:0]  req_op, l2_op, fill_op;
  logic [31:0] req_addr, l2_addr, fill_addr;
  logic [3:0]  count;
  logic        rv_auto = 1'b0;
  logic        rv_man  = 1'b0;
`ifdef L2Q_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_stalls;
`endif

  always #5 clk = ~clk;
  assign l2_rvalid = rv_auto | rv_man;

  l1_l2_request_queue #(
    .DEPTH    (8),
    .ADDR_W   (32),
    .OFFSET_W (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .l2_valid   (l2_valid),
    .l2_ready   (l2_ready),
    .l2_op      (l2_op),
    .l2_addr    (l2_addr),
    .l2_rvalid  (l2_rvalid),
    .fill_valid (fill_valid),
    .fill_op    (fill_op),
    .fill_addr  (fill_addr),
    .count      (count),
    .busy       (busy)
`ifdef L2Q_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_stalls (stat_stalls)
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_l2[$];
  exp_t exp_fill[$];
  int   hs_cycles[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_total = 0;
  int   fills = 0;
  int   hs_cyc = 0;
  int   fill_cyc = 0;
  int   rdelay = 3;
  logic rd_out = 1'b0;
  bit   resp_en = 1'b1;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:6], 6'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One push attempt; the expected entry is recorded only if the DUT accepts it
  task automatic try_once(input logic [1:0] op, input logic [31:0] addr, output bit accepted);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    accepted  = req_ready;
    if (accepted) begin
      exp_l2.push_back('{op, align(addr)});
      if (!op[0]) exp_fill.push_back('{op, align(addr)});
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [31:0] addr);
    bit acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) try_once(op, addr, acc);
    check("push_accept", acc, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_l2.size() == 0 && exp_fill.size() == 0 && !busy) done = 1'b1;
      else tick();
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_l2_valid"}, l2_valid, 0);
    check({tag, "_fill_valid"}, fill_valid, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_count"}, count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_l2_op"}, l2_op, 0);
    check({tag, "_l2_addr"}, l2_addr, 0);
    check({tag, "_fill_op"}, fill_op, 0);
    check({tag, "_fill_addr"}, fill_addr, 0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, between active edges
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rd_out = 1'b0;
      end else begin
        if (rd_out) check("no_valid_in_wait", l2_valid, 0);
        if (l2_valid && l2_ready) begin
          hs_total++;
          hs_cyc = cyc;
          hs_cycles.push_back(cyc);
          check("l2_sb_nonempty", exp_l2.size() != 0, 1);
          if (exp_l2.size() != 0) begin
            e = exp_l2.pop_front();
            check("l2_op", l2_op, e.op);
            check("l2_addr", l2_addr, e.addr);
          end
          if (!l2_op[0]) rd_out = 1'b1;
        end
        if (fill_valid) begin
          fills++;
          fill_cyc = cyc;
          check("fill_sb_nonempty", exp_fill.size() != 0, 1);
          if (exp_fill.size() != 0) begin
            e = exp_fill.pop_front();
            check("fill_op", fill_op, e.op);
            check("fill_addr", fill_addr, e.addr);
          end
          rd_out = 1'b0;
        end
      end
    end
  endtask

  // L2 read responder: l2_rvalid sampled rdelay edges after the read handshake edge
  task automatic responder();
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && l2_valid && l2_ready && !l2_op[0]) begin
        repeat (rdelay) @(posedge clk);
        #1 rv_auto = 1'b1;
        @(posedge clk);
        #1 rv_auto = 1'b0;
      end
    end
  endtask

  initial begin
    bit acc;
    int base_hs, base_fill;
    logic [31:0] head_exp;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; l2_ready = 1'b0;
    fork
      monitor();
      responder();
    join_none

    // Reset state
    tick(3);
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Single DATA_READ: latency, alignment, fill
    l2_ready = 1'b1;
    rdelay = 3;
    base_fill = fills;
    push_req(DATA_READ, 32'h1234_5678);
    check("rd_lat_valid_t0", l2_valid, 0);
    check("rd_count_1", count, 1);
    tick();
    check("rd_lat_valid_t1", l2_valid, 1);
    check("rd_l2_addr_aligned", l2_addr, 32'h1234_5640);
    wait_idle("rd_idle");
    check("rd_fill_seen", fills - base_fill, 1);
    check("rd_count_0", count, 0);

    // Four back-to-back write-throughs
    hs_cycles.delete();
    for (int i = 0; i < 4; i++) push_req(DATA_WRITE_THROUGH, 32'h4000_0000 + 32'(i * 64 + i));
    wait_idle("wt_idle");
    check("wt_hs_count", hs_cycles.size(), 4);
    if (hs_cycles.size() == 4) check("wt_hs_back_to_back", hs_cycles[3] - hs_cycles[0], 3);
    check("wt_busy_low", busy, 0);

    // Read then write-back with slow response
    rdelay = 10;
    base_fill = fills;
    push_req(INSTR_READ, 32'h5000_00BF);
    push_req(DATA_WRITE_BACK, 32'h5000_0105);
    wait_idle("rw_idle");
    check("rw_fill_seen", fills - base_fill, 1);
    check("rw_write_after_fill", hs_cyc > fill_cyc, 1);

    // Fill to DEPTH with L2 stalled, then drain while pushing through the wrap
    rdelay = 2;
    l2_ready = 1'b0;
    base_hs = hs_total;
    for (int i = 0; i < 8; i++)
      push_req((i % 2 == 0) ? DATA_WRITE_THROUGH : DATA_WRITE_BACK, 32'h1000_0000 + 32'(i * 64 + i));
    check("full_count", count, 8);
    check("full_req_ready", req_ready, 0);
    try_once(DATA_WRITE_BACK, 32'hDEAD_0000, acc);
    check("full_push_refused", acc, 0);
    head_exp = exp_l2[0].addr;
    check("stall_valid", l2_valid, 1);
    check("stall_addr", l2_addr, head_exp);
    tick(3);
    check("stall_addr_stable", l2_addr, head_exp);
    check("stall_op_stable", l2_op, DATA_WRITE_THROUGH);
    l2_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      push_req((i == 3) ? DATA_READ : DATA_WRITE_THROUGH, 32'h2000_0000 + 32'(i * 64 + 7));
    wait_idle("wrap_idle");
    check("wrap_hs_total", hs_total - base_hs, 16);

    // Reset while a read is outstanding
    resp_en = 1'b0;
    base_fill = fills;
    push_req(DATA_READ, 32'h6000_0040);
    for (int i = 0; i < 20 && !rd_out; i++) tick();
    check("mid_rd_outstanding", rd_out, 1);
    tick(2);
    rst_n = 1'b0;
    tick(2);
    exp_l2.delete();
    exp_fill.delete();
    rst_n = 1'b1;
    rv_man = 1'b1;
    tick();
    rv_man = 1'b0;
    tick(3);
    check("mid_no_fill", fills - base_fill, 0);
    check_reset_values("mid");
    resp_en = 1'b1;

`ifdef L2Q_STATS_EN
    // Statistics: 3 reads, 2 writes, 5 stall cycles
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    rdelay = 2;
    l2_ready = 1'b0;
    push_req(DATA_READ, 32'h7000_0000);
    tick();
    check("st_valid_before_stall", l2_valid, 1);
    tick(5);
    l2_ready = 1'b1;
    push_req(INSTR_READ, 32'h7000_0040);
    push_req(DATA_WRITE_THROUGH, 32'h7000_0080);
    push_req(DATA_READ, 32'h7000_00C0);
    push_req(DATA_WRITE_BACK, 32'h7000_0100);
    wait_idle("st_idle");
    check("stat_reads", stat_reads, 3);
    check("stat_writes", stat_writes, 2);
    check("stat_stalls", stat_stalls, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
